dmem_lsu: RTL and testbench

Load/store unit for the MEM stage of the pipeline. It drives a handshaked, word-wide data-memory port on behalf of the pipeline, and is the initiator for that memory rather than the memory itself. It converts each byte-addressed RV32I load or store into one or two aligned word transactions with byte enables, and performs sign or zero extension on loads. It stalls the pipeline until the access completes, and splits misaligned accesses across two words.

---
 rtl/dmem_lsu.sv | 159 +++++++++++++++
 tb/tb_dmem_lsu.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// Load/store unit for the MEM stage: turns byte-addressed RV32I loads/stores into
// one or two aligned, byte-enabled word transactions and extends load results.
module dmem_lsu #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] a,
    input  logic [DATA_W-1:0]     wd,
    input  logic [2:0]            Funct3,
    output logic [DATA_W-1:0]     rd,
    output logic                  rd_valid,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

    state_t                state_q, state_d;
    logic                  is_load_q, is_load_d;
    logic [DATA_W-1:0]     rd_q, rd_d;
    logic [DM_ADDRESS-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     wd_q, wd_d;
    logic [2:0]            f3_q, f3_d;
    logic [DATA_W-1:0]     asm_q, asm_d;

    logic [1:0]            off;
    logic [3:0]            size_mask;
    logic                  split;
    logic [7:0]            be_wide;
    logic [2*DATA_W-1:0]   wdata_wide;
    logic [2*DATA_W-1:0]   load_wide;
    logic [DATA_W-1:0]     load_word;
    logic [DM_ADDRESS-1:0] word_addr;

    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v,
                                                 input logic [2:0]        f3);
        case (f3[1:0])
            2'b00:   extend = f3[2] ? {{(DATA_W-8){1'b0}}, v[7:0]}
                                    : {{(DATA_W-8){v[7]}}, v[7:0]};
            2'b01:   extend = f3[2] ? {{(DATA_W-16){1'b0}}, v[15:0]}
                                    : {{(DATA_W-16){v[15]}}, v[15:0]};
            default: extend = v;
        endcase
    endfunction

    // Both beats come from one double-word view: low half is beat0, high half is beat1.
    assign off        = addr_q[1:0];
    assign size_mask  = (f3_q[1:0] == 2'b00) ? 4'b0001 :
                        (f3_q[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
    assign split      = ((f3_q[1:0] == 2'b01) && (off == 2'd3)) ||
                        (f3_q[1] && (off != 2'd0));
    assign be_wide    = {4'b0000, size_mask} << off;
    assign wdata_wide = {{DATA_W{1'b0}}, wd_q} << {off, 3'b000};
    assign load_wide  = split ? {mem_rdata, asm_q} : {{DATA_W{1'b0}}, mem_rdata};
    assign load_word  = DATA_W'(load_wide >> {off, 3'b000});
    assign word_addr  = {addr_q[DM_ADDRESS-1:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            is_load_q <= 1'b0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            is_load_q <= is_load_d;
            rd_q      <= rd_d;
        end
    end

    // Request latches only matter while a transaction is in flight.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        wd_q   <= wd_d;
        f3_q   <= f3_d;
        asm_q  <= asm_d;
    end

    always_comb begin
        state_d   = state_q;
        is_load_d = is_load_q;
        rd_d      = rd_q;
        addr_d    = addr_q;
        wd_d      = wd_q;
        f3_d      = f3_q;
        asm_d     = asm_q;
        case (state_q)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    addr_d    = a;
                    wd_d      = wd;
                    f3_d      = Funct3;
                    is_load_d = MemRead;
                    state_d   = BEAT0;
                end
            end
            BEAT0: begin
                if (mem_ack) begin
                    if (split) begin
                        asm_d   = mem_rdata;
                        state_d = BEAT1;
                    end else begin
                        if (is_load_q) rd_d = extend(load_word, f3_q);
                        state_d = DONE;
                    end
                end
            end
            BEAT1: begin
                if (mem_ack) begin
                    if (is_load_q) rd_d = extend(load_word, f3_q);
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = 4'b0000;
        mem_wdata = '0;
        rd_valid  = 1'b0;
        stall     = 1'b0;
        case (state_q)
            IDLE: stall = MemRead || MemWrite;
            BEAT0: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = !is_load_q;
                mem_addr  = word_addr;
                mem_be    = be_wide[3:0];
                mem_wdata = is_load_q ? '0 : wdata_wide[DATA_W-1:0];
            end
            BEAT1: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = !is_load_q;
                mem_addr  = word_addr + DM_ADDRESS'(4);
                mem_be    = be_wide[7:4];
                mem_wdata = is_load_q ? '0 : wdata_wide[2*DATA_W-1:DATA_W];
            end
            default: rd_valid = is_load_q;
        endcase
    end

    assign rd = rd_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: a table of load/store vectors driven through a
// bench-side memory responder, plus reset, wait-state and stray-ack sequences.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [8:0]  a = '0;
    logic [31:0] wd = '0;
    logic [2:0]  Funct3 = '0;
    logic [31:0] rd;
    logic        rd_valid;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int errors = 0;
    int checks = 0;
    logic [31:0] last_rd = '0;

    typedef struct {
        logic        rd_en;
        logic        wr_en;
        logic [2:0]  f3;
        logic [8:0]  a;
        logic [31:0] wd;
        logic [31:0] rdata0;
        logic [31:0] rdata1;
        logic        split;
        logic [8:0]  addr0;
        logic [3:0]  be0;
        logic [31:0] wdata0;
        logic [8:0]  addr1;
        logic [3:0]  be1;
        logic [31:0] wdata1;
        logic [31:0] exp_rd;
        int          waits;
    } vec_t;

    vec_t vecs[12];

    dmem_lsu #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .a(a), .wd(wd), .Funct3(Funct3), .rd(rd), .rd_valid(rd_valid),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int  beat;
        int  cyc;
        int  w;
        int  nb;
        bit  done;
        nb = v.split ? 2 : 1;
        @(negedge clk);
        MemRead  = v.rd_en;
        MemWrite = v.wr_en;
        a        = v.a;
        wd       = v.wd;
        Funct3   = v.f3;
        mem_ack  = 1'b0;
        #1;
        chk({tag, " req_stall"}, stall, 1'b1);
        chk({tag, " req_idle"}, mem_req, 1'b0);
        beat = 0; w = 0; cyc = 0; done = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            mem_ack = 1'b0;
            #1;
            if (mem_req) begin
                chk({tag, " stall"}, stall, 1'b1);
                chk({tag, " we"}, mem_we, v.wr_en && !v.rd_en);
                chk({tag, " addr"}, mem_addr, (beat == 0) ? v.addr0 : v.addr1);
                chk({tag, " be"}, mem_be, (beat == 0) ? v.be0 : v.be1);
                if (!v.rd_en)
                    chk({tag, " wdata"}, mem_wdata, (beat == 0) ? v.wdata0 : v.wdata1);
                if (w < v.waits) begin
                    w++;
                end else begin
                    mem_ack   = 1'b1;
                    mem_rdata = (beat == 0) ? v.rdata0 : v.rdata1;
                    beat++;
                    w = 0;
                end
            end else begin
                done = 1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got no completion within %0d cycles, required one", tag, cyc);
        end else begin
            chk({tag, " beats"}, beat, nb);
            chk({tag, " latency"}, cyc, nb * (1 + v.waits) + 1);
            chk({tag, " done_stall"}, stall, 1'b0);
            chk({tag, " rd_valid"}, rd_valid, v.rd_en);
            if (v.rd_en) last_rd = v.exp_rd;
            chk({tag, " rd"}, rd, last_rd);
        end
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(negedge clk);
        #1;
        chk({tag, " post_valid"}, rd_valid, 1'b0);
        chk({tag, " post_req"}, mem_req, 1'b0);
        chk({tag, " post_rd"}, rd, last_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        // rd_en wr_en f3 a wd rdata0 rdata1 split addr0 be0 wdata0 addr1 be1 wdata1 exp_rd waits
        vecs[0]  = '{1'b0, 1'b1, 3'b010, 9'h010, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0,
                     9'h010, 4'b1111, 32'hDEADBEEF, 9'h000, 4'b0000, 32'h0, 32'h0, 0};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 9'h023, 32'h0, 32'h80FFFFFF, 32'h0, 1'b0,
                     9'h020, 4'b1000, 32'h0, 9'h000, 4'b0000, 32'h0, 32'hFFFFFF80, 0};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 9'h023, 32'h0, 32'h80FFFFFF, 32'h0, 1'b0,
                     9'h020, 4'b1000, 32'h0, 9'h000, 4'b0000, 32'h0, 32'h00000080, 0};
        vecs[3]  = '{1'b0, 1'b1, 3'b001, 9'h013, 32'h0000ABCD, 32'h0, 32'h0, 1'b1,
                     9'h010, 4'b1000, 32'hCD000000, 9'h014, 4'b0001, 32'h000000AB, 32'h0, 0};
        vecs[4]  = '{1'b1, 1'b0, 3'b010, 9'h1FE, 32'h0, 32'h22110000, 32'h00004433, 1'b1,
                     9'h1FC, 4'b1100, 32'h0, 9'h000, 4'b0011, 32'h0, 32'h44332211, 0};
        vecs[5]  = '{1'b1, 1'b0, 3'b001, 9'h002, 32'h0, 32'h80010000, 32'h0, 1'b0,
                     9'h000, 4'b1100, 32'h0, 9'h000, 4'b0000, 32'h0, 32'hFFFF8001, 0};
        vecs[6]  = '{1'b1, 1'b0, 3'b101, 9'h002, 32'h0, 32'h80010000, 32'h0, 1'b0,
                     9'h000, 4'b1100, 32'h0, 9'h000, 4'b0000, 32'h0, 32'h00008001, 0};
        vecs[7]  = '{1'b0, 1'b1, 3'b000, 9'h005, 32'h12345678, 32'h0, 32'h0, 1'b0,
                     9'h004, 4'b0010, 32'h34567800, 9'h000, 4'b0000, 32'h0, 32'h0, 0};
        vecs[8]  = '{1'b1, 1'b0, 3'b110, 9'h008, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0,
                     9'h008, 4'b1111, 32'h0, 9'h000, 4'b0000, 32'h0, 32'hCAFEF00D, 0};
        vecs[9]  = '{1'b1, 1'b0, 3'b001, 9'h00B, 32'h0, 32'h7F000000, 32'h000000FF, 1'b1,
                     9'h008, 4'b1000, 32'h0, 9'h00C, 4'b0001, 32'h0, 32'hFFFFFF7F, 0};
        vecs[10] = '{1'b0, 1'b1, 3'b010, 9'h031, 32'h11223344, 32'h0, 32'h0, 1'b1,
                     9'h030, 4'b1110, 32'h22334400, 9'h034, 4'b0001, 32'h00000011, 32'h0, 0};
        vecs[11] = '{1'b1, 1'b1, 3'b010, 9'h040, 32'h55555555, 32'h01020304, 32'h0, 1'b0,
                     9'h040, 4'b1111, 32'h0, 9'h000, 4'b0000, 32'h0, 32'h01020304, 0};

        repeat (2) @(negedge clk);
        #1;
        chk("rst mem_req", mem_req, 1'b0);
        chk("rst rd", rd, 32'h0);
        chk("rst be", mem_be, 4'b0000);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("idle stall", stall, 1'b0);
        chk("idle rd_valid", rd_valid, 1'b0);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Stray ack with no request outstanding must not start anything.
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        #1;
        chk("stray_ack req", mem_req, 1'b0);
        chk("stray_ack stall", stall, 1'b0);
        chk("stray_ack valid", rd_valid, 1'b0);
        mem_ack = 1'b0;

        // LW with three wait states per beat: DONE on cycle 5.
        v = '{1'b1, 1'b0, 3'b010, 9'h0A0, 32'h0, 32'hA5A50F0F, 32'h0, 1'b0,
              9'h0A0, 4'b1111, 32'h0, 9'h000, 4'b0000, 32'h0, 32'hA5A50F0F, 3};
        run_vec(v, "lw_wait3");

        // Split SW with one wait state on each beat.
        v = '{1'b0, 1'b1, 3'b010, 9'h0A2, 32'hAABBCCDD, 32'h0, 32'h0, 1'b1,
              9'h0A0, 4'b1100, 32'hCCDD0000, 9'h0A4, 4'b0011, 32'h0000AABB, 32'h0, 1};
        run_vec(v, "sw_split_wait");

        // Reset during BEAT0 of a store.
        @(negedge clk);
        MemWrite = 1'b1;
        a        = 9'h010;
        wd       = 32'h87654321;
        Funct3   = 3'b010;
        @(negedge clk);
        #1;
        chk("mid beat0 req", mem_req, 1'b1);
        rst_n    = 1'b0;
        #1;
        chk("mid rst req", mem_req, 1'b0);
        chk("mid rst we", mem_we, 1'b0);
        chk("mid rst addr", mem_addr, 9'h000);
        chk("mid rst be", mem_be, 4'b0000);
        chk("mid rst wdata", mem_wdata, 32'h0);
        chk("mid rst rd", rd, 32'h0);
        chk("mid rst valid", rd_valid, 1'b0);
        MemWrite = 1'b0;
        last_rd  = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post rst stall", stall, 1'b0);
        chk("post rst req", mem_req, 1'b0);
        run_vec(vecs[8], "lw_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
